// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scanner: segment patterns,
// the blank pattern, the digit-index type and a digit-enable helper.
// Patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;

  // Active-low one-hot digit enable for a given index.
  function automatic logic [3:0] digit_an(digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to seven-segment pattern decoder.
// Ports: nib_i (4-bit hex digit), seg_o (active-low {g,f,e,d,c,b,a}).
// No state, no latency.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nib_i)
      4'h0: seg_o = SEG_HEX_0;
      4'h1: seg_o = SEG_HEX_1;
      4'h2: seg_o = SEG_HEX_2;
      4'h3: seg_o = SEG_HEX_3;
      4'h4: seg_o = SEG_HEX_4;
      4'h5: seg_o = SEG_HEX_5;
      4'h6: seg_o = SEG_HEX_6;
      4'h7: seg_o = SEG_HEX_7;
      4'h8: seg_o = SEG_HEX_8;
      4'h9: seg_o = SEG_HEX_9;
      4'hA: seg_o = SEG_HEX_A;
      4'hB: seg_o = SEG_HEX_B;
      4'hC: seg_o = SEG_HEX_C;
      4'hD: seg_o = SEG_HEX_D;
      4'hE: seg_o = SEG_HEX_E;
      4'hF: seg_o = SEG_HEX_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment scanner. Each digit slot lasts
// REFRESH_DIV clocks; an/seg are registered one cycle behind the digit
// index and display register. Synchronous active-high reset.
// Ports: clock, reset, value[15:0] + load (display capture), an[3:0]
// (active-low one-hot digit enable), seg[6:0] (active-low {g,f,e,d,c,b,a}).
// Optional macro SEG7_BLANK_EN: blank leading zero digits 3..1.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] TICK_MAX = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] tick_q, tick_d;
  digit_idx_t    idx_q, idx_d;
  logic [15:0]   disp_q, disp_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic [3:0]    cur_nib;
  logic [6:0]    dec_seg;
  logic          blank;

  // Outputs are built from the pre-edge index and register, so a load
  // landing on a slot change only reaches seg one cycle later.
  assign cur_nib = disp_q[{idx_q, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .nib_i (cur_nib),
    .seg_o (dec_seg)
  );

`ifdef SEG7_BLANK_EN
  // A digit is a leading zero when it and every higher nibble are zero.
  // Digit 0 always shows, so a zero value still displays "0".
  always_comb begin
    blank = 1'b0;
    case (idx_q)
      2'd3:    blank = (disp_q[15:12] == 4'h0);
      2'd2:    blank = (disp_q[15:8]  == 8'h00);
      2'd1:    blank = (disp_q[15:4]  == 12'h000);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    tick_d = (tick_q == TICK_MAX) ? '0 : tick_q + 1'b1;
    idx_d  = (tick_q == TICK_MAX) ? idx_q + 2'd1 : idx_q;
    disp_d = load ? value : disp_q;
    an_d   = digit_an(idx_q);
    seg_d  = blank ? SEG_BLANK : dec_seg;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tick_q <= '0;
      idx_q  <= '0;
      disp_q <= 16'h0000;
      an_q   <= 4'b1111;
      seg_q  <= SEG_BLANK;
    end else begin
      tick_q <= tick_d;
      idx_q  <= idx_d;
      disp_q <= disp_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Randomized self-checking bench for seg7_scan. Two instances (slot
// lengths 4 and 2) share stimulus; a behavioural model predicts the
// shown digit from the count of cycles since reset and the register value.
module tb_seg7_scan;

  localparam int DIV_A = 4;
  localparam int DIV_B = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic [3:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;

  always #5 clock = ~clock;

  seg7_scan #(.REFRESH_DIV(DIV_A)) dut_a (
    .clock (clock),
    .reset (reset),
    .value (value),
    .load  (load),
    .an    (an_a),
    .seg   (seg_a)
  );

  seg7_scan #(.REFRESH_DIV(DIV_B)) dut_b (
    .clock (clock),
    .reset (reset),
    .value (value),
    .load  (load),
    .an    (an_b),
    .seg   (seg_b)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [6:0]  hex_tab [16];

  // Model state: edges since reset release, display value, last edge reset?
  int          m_cnt;
  logic [15:0] m_reg;
  logic        m_rst;
  logic [3:0]  e_an_a, e_an_b;
  logic [6:0]  e_seg_a, e_seg_b;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Shown digit = which slot the cycle count falls into; the pattern
  // comes from the register value held before this edge.
  function automatic logic [10:0] model_out(input int div, input int cnt, input logic [15:0] r);
    int         k;
    logic [3:0] a;
    logic [6:0] s;
    logic [15:0] upper;
    k = (cnt / div) % 4;
    for (int i = 0; i < 4; i++) a[i] = (i != k);
    upper = r >> (4 * k);
    s = hex_tab[upper[3:0]];
`ifdef SEG7_BLANK_EN
    if (k > 0 && upper == 16'h0) s = 7'b1111111;
`endif
    return {a, s};
  endfunction

  task automatic step(input logic rst, input logic ld, input logic [15:0] v);
    reset = rst;
    load  = ld;
    value = v;
    if (rst) begin
      e_an_a = 4'hF; e_seg_a = 7'h7F;
      e_an_b = 4'hF; e_seg_b = 7'h7F;
      m_cnt = 0;
      m_reg = 16'h0;
      m_rst = 1'b1;
    end else begin
      {e_an_a, e_seg_a} = model_out(DIV_A, m_cnt, m_reg);
      {e_an_b, e_seg_b} = model_out(DIV_B, m_cnt, m_reg);
      if (ld) m_reg = v;
      m_cnt++;
      m_rst = 1'b0;
    end
    @(posedge clock);
    @(negedge clock);
    cyc++;
    check_val("an_div4",  {12'h0, an_a},  {12'h0, e_an_a});
    check_val("seg_div4", {9'h0, seg_a},  {9'h0, e_seg_a});
    check_val("an_div2",  {12'h0, an_b},  {12'h0, e_an_b});
    check_val("seg_div2", {9'h0, seg_b},  {9'h0, e_seg_b});
    if (!m_rst) begin
      check_val("onehot_div4", 16'($countones(~an_a)), 16'd1);
      check_val("onehot_div2", 16'($countones(~an_b)), 16'd1);
    end
  endtask

  initial begin
    logic [15:0] tbl [16];
    tbl = '{16'h40, 16'h79, 16'h24, 16'h30, 16'h19, 16'h12, 16'h02, 16'h78,
            16'h00, 16'h10, 16'h08, 16'h03, 16'h46, 16'h21, 16'h06, 16'h0E};
    for (int i = 0; i < 16; i++) hex_tab[i] = tbl[i][6:0];

    reset = 1'b1; load = 1'b0; value = 16'h0;
    m_cnt = 0; m_reg = 16'h0; m_rst = 1'b1;

    // Reset state
    step(1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b0, 16'h0);
    check_val("rst_an", {12'h0, an_a}, 16'h000F);
    check_val("rst_seg", {9'h0, seg_a}, 16'h007F);

    // Load 0x12AF on the first released edge, then scan several rounds
    step(1'b0, 1'b1, 16'h12AF);
    check_val("release_an", {12'h0, an_a}, 16'h000E);
    check_val("release_seg", {9'h0, seg_a}, 16'h0040);
    repeat (24) step(1'b0, 1'b0, 16'($urandom));

    // Reset mid-scan while loading 0xFFFF; reset must win
    repeat (2) step(1'b0, 1'b0, 16'($urandom));
    repeat (3) step(1'b1, 1'b1, 16'hFFFF);
    check_val("midrst_an", {12'h0, an_a}, 16'h000F);
    check_val("midrst_seg", {9'h0, seg_a}, 16'h007F);
    step(1'b0, 1'b0, 16'($urandom));
    check_val("postrst_an", {12'h0, an_a}, 16'h000E);
    check_val("postrst_seg", {9'h0, seg_a}, 16'h0040);
    repeat (12) step(1'b0, 1'b0, 16'($urandom));

    // Reload while digit 0 is active: seg moves 5 -> 6 one cycle after the load edge
    step(1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'h0005);
    step(1'b0, 1'b1, 16'h0006);
    check_val("reload_seg5", {9'h0, seg_a}, 16'h0012);
    check_val("reload_an5", {12'h0, an_a}, 16'h000E);
    step(1'b0, 1'b0, 16'h0);
    check_val("reload_seg6", {9'h0, seg_a}, 16'h0002);
    check_val("reload_an6", {12'h0, an_a}, 16'h000E);
    repeat (6) step(1'b0, 1'b0, 16'($urandom));

    // Leading-zero case
    step(1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'h0040);
    repeat (20) step(1'b0, 1'b0, 16'($urandom));

    // Random loads with occasional resets
    for (int n = 0; n < 10000; n++) begin
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) == 0), 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
